nn_sample_driver: RTL

// - Host-side driver for the nn iris classifier. Accepts the four features (sl, sw, pl, pw) one at a time

---
 rtl/nn_sample_driver_pkg.sv | 22 ++
 rtl/nn_settle_timer.sv | 35 +++
 rtl/nn_sample_driver.sv | 130 +++++++++++++
 3 files changed

// File: rtl/nn_sample_driver_pkg.sv
// Shared state encoding and helpers for the nn sample driver.
// Feature, species and score widths default to 4, 4 and 32 bits.
`timescale 1ns/100ps
package nn_sample_driver_pkg;

  localparam int FEAT_W_DEF    = 4;
  localparam int SPECIES_W_DEF = 4;
  localparam int SCORE_W_DEF   = 32;
  localparam int NUM_SLOTS     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    RESULT = 2'd3
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s == SETTLE) || (s == RESULT);
  endfunction

endpackage

// File: rtl/nn_settle_timer.sv
// Settle counter: cleared on load, counts while enabled, and flags the
// last cycle of the settle window.
`timescale 1ns/100ps
module nn_settle_timer #(
  parameter int SETTLE_CYC = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int TW = 8;

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign done = (cnt_q == TW'(SETTLE_CYC - 1));

endmodule

// File: rtl/nn_sample_driver.sv
// Host-side driver for the nn classifier: collects four feature beats,
// holds them stable for a settle window, then returns species/score.
`timescale 1ns/100ps
module nn_sample_driver
  import nn_sample_driver_pkg::*;
#(
  parameter int FEAT_W     = FEAT_W_DEF,
  parameter int SPECIES_W  = SPECIES_W_DEF,
  parameter int SCORE_W    = SCORE_W_DEF,
  parameter int SETTLE_CYC = 8,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FEAT_W-1:0]    in_data,
  output logic [FEAT_W-1:0]    nn_sl,
  output logic [FEAT_W-1:0]    nn_sw,
  output logic [FEAT_W-1:0]    nn_pl,
  output logic [FEAT_W-1:0]    nn_pw,
  input  logic [SPECIES_W-1:0] nn_species,
  input  logic [SCORE_W-1:0]   nn_final,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SPECIES_W-1:0] res_species,
  output logic [SCORE_W-1:0]   res_final,
  output logic                 busy,
  output logic [CNT_W-1:0]     sample_cnt
);

  state_e                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [FEAT_W-1:0]      slot_q [NUM_SLOTS];
  logic [FEAT_W-1:0]      slot_d [NUM_SLOTS];
  logic                   in_ready_q, in_ready_d;
  logic                   res_valid_q, res_valid_d;
  logic                   busy_q, busy_d;
  logic [SPECIES_W-1:0]   res_species_q, res_species_d;
  logic [SCORE_W-1:0]     res_final_q, res_final_d;
  logic [CNT_W-1:0]       sample_cnt_q, sample_cnt_d;

  logic accept, last_beat, timer_done;

  // in_ready_q is high exactly while in LOAD, so it doubles as the state qualifier.
  assign accept    = in_valid & in_ready_q;
  assign last_beat = accept && (idx_q == 2'd3);

  nn_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (last_beat),
    .en    (state_q == SETTLE),
    .done  (timer_done)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    slot_d        = slot_q;
    res_species_d = res_species_q;
    res_final_d   = res_final_q;
    sample_cnt_d  = sample_cnt_q;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (accept) begin
          slot_d[idx_q] = in_data;
          idx_d         = idx_q + 2'd1;
          if (last_beat)
            state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (timer_done) begin
          res_species_d = nn_species;
          res_final_d   = nn_final;
          state_d       = RESULT;
        end
      end
      RESULT: begin
        if (res_valid_q && res_ready) begin
          sample_cnt_d = sample_cnt_q + 1'b1;
          state_d      = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    // Status outputs are registered from the next state so they line up with it.
    in_ready_d  = (state_d == LOAD);
    res_valid_d = (state_d == RESULT);
    busy_d      = is_busy(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
      in_ready_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      res_species_q <= '0;
      res_final_q   <= '0;
      sample_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      slot_q        <= slot_d;
      in_ready_q    <= in_ready_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
      res_species_q <= res_species_d;
      res_final_q   <= res_final_d;
      sample_cnt_q  <= sample_cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign nn_sl       = slot_q[0];
  assign nn_sw       = slot_q[1];
  assign nn_pl       = slot_q[2];
  assign nn_pw       = slot_q[3];
  assign res_valid   = res_valid_q;
  assign res_species = res_species_q;
  assign res_final   = res_final_q;
  assign busy        = busy_q;
  assign sample_cnt  = sample_cnt_q;

endmodule
